// File: rtl/mcp23s17_spi_responder.sv
// MCP23S17-compatible SPI mode-0 responder (BANK=0 register map) with
// compare-to-previous pin interrupts, running entirely in the clk domain.
module mcp23s17_spi_responder #(
    parameter logic [2:0] HW_ADDR     = 3'b000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_cs_n,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] gpio_a_in,
    input  logic [7:0] gpio_b_in,
    output logic [7:0] gpio_a_out,
    output logic [7:0] gpio_b_out,
    output logic [7:0] gpio_a_dir,
    output logic [7:0] gpio_b_dir,
    output logic [7:0] gpio_a_pu,
    output logic [7:0] gpio_b_pu,
    output logic       inta,
    output logic       intb,
    output logic       inta_oe,
    output logic       intb_oe
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OPCODE = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic [7:0] gpa_sync [SYNC_STAGES];
    logic [7:0] gpb_sync [SYNC_STAGES];
    logic       cs_s, sck_s, mosi_s, cs_prev, sck_prev;
    logic [7:0] gpa_s, gpb_s, gpa_prev, gpb_prev;

    state_t     state, state_nxt;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sh;
    logic [7:0] rx_byte, tx_sh, ptr, ptr_inc, rd_data;
    logic       rw, load_pend, miso_oe_r;
    logic       sck_rise, sck_fall, cs_fall, byte_done, wr_en, ld_en;

    logic [7:0] iodir_a, iodir_b, gpinten_a, gpinten_b, gppu_a, gppu_b;
    logic [7:0] olat_a, olat_b, intf_a, intf_b, intcap_a, intcap_b, iocon;
    logic [7:0] chg_a, chg_b;
    logic       clr_a, clr_b, act_a, act_b, pin_a, pin_b;
    logic       inta_r, intb_r, inta_oe_r, intb_oe_r;

    logic mirror, seqop, haen, odr, intpol;
    assign mirror = iocon[6];
    assign seqop  = iocon[5];
    assign haen   = iocon[3];
    assign odr    = iocon[2];
    assign intpol = iocon[1];

    // Input synchronisers and edge history; left unreset so a reset pulse
    // during a frame cannot fabricate a cs_n falling edge.
    always_ff @(posedge clk) begin
        cs_sync     <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
        sck_sync    <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
        mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        gpa_sync[0] <= gpio_a_in;
        gpb_sync[0] <= gpio_b_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            gpa_sync[i] <= gpa_sync[i-1];
            gpb_sync[i] <= gpb_sync[i-1];
        end
        cs_prev  <= cs_s;
        sck_prev <= sck_s;
        gpa_prev <= gpa_s;
        gpb_prev <= gpb_s;
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign gpa_s     = gpa_sync[SYNC_STAGES-1];
    assign gpb_s     = gpb_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev;
    assign sck_fall  = ~sck_s & sck_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sh, mosi_s};
    assign wr_en     = byte_done && (state == ST_DATA) && !rw;
    assign ld_en     = sck_fall && load_pend && (state != ST_IDLE) && !cs_s;
    assign ptr_inc   = seqop ? ptr : ((ptr == 8'h15) ? 8'h00 : ptr + 8'd1);

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame next-state decode; chip select high overrides everything
    always_comb begin
        state_nxt = state;
        if (cs_s) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) state_nxt = ST_OPCODE;
                    else         state_nxt = ST_IDLE;
                end
                ST_OPCODE: begin
                    if (!byte_done)
                        state_nxt = ST_OPCODE;
                    else if ((rx_byte[7:4] != 4'b0100) || (haen && (rx_byte[3:1] != HW_ADDR)))
                        state_nxt = ST_IGNORE;
                    else
                        state_nxt = ST_ADDR;
                end
                ST_ADDR: begin
                    if (byte_done) state_nxt = ST_DATA;
                    else           state_nxt = ST_ADDR;
                end
                ST_DATA:   state_nxt = ST_DATA;
                ST_IGNORE: state_nxt = ST_IGNORE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Shift registers, bit counter, register pointer and TX loading
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            rx_sh     <= 7'd0;
            rw        <= 1'b0;
            ptr       <= 8'h00;
            load_pend <= 1'b0;
            tx_sh     <= 8'h00;
            miso_oe_r <= 1'b0;
        end else begin
            miso_oe_r <= (state == ST_DATA) && rw && !cs_s;
            if ((state == ST_IDLE) || cs_s) begin
                bit_cnt   <= 3'd0;
                load_pend <= 1'b0;
            end else begin
                if (sck_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sh   <= {rx_sh[5:0], mosi_s};
                end
                if (byte_done) begin
                    case (state)
                        ST_OPCODE: rw <= rx_byte[0];
                        ST_ADDR: begin
                            ptr       <= rx_byte;
                            load_pend <= rw;
                        end
                        ST_DATA: begin
                            if (rw) load_pend <= 1'b1;
                            else    ptr       <= ptr_inc;
                        end
                        default: ;
                    endcase
                end
                if (sck_fall) begin
                    if (load_pend) begin
                        tx_sh     <= rd_data;
                        ptr       <= ptr_inc;
                        load_pend <= 1'b0;
                    end else begin
                        tx_sh <= {tx_sh[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // Register read multiplexer
    always_comb begin
        rd_data = 8'h00;
        case (ptr)
            8'h00:        rd_data = iodir_a;
            8'h01:        rd_data = iodir_b;
            8'h04:        rd_data = gpinten_a;
            8'h05:        rd_data = gpinten_b;
            8'h0A, 8'h0B: rd_data = iocon;
            8'h0C:        rd_data = gppu_a;
            8'h0D:        rd_data = gppu_b;
            8'h0E:        rd_data = intf_a;
            8'h0F:        rd_data = intf_b;
            8'h10:        rd_data = intcap_a;
            8'h11:        rd_data = intcap_b;
            8'h12:        rd_data = (iodir_a & gpa_s) | (~iodir_a & olat_a);
            8'h13:        rd_data = (iodir_b & gpb_s) | (~iodir_b & olat_b);
            8'h14:        rd_data = olat_a;
            8'h15:        rd_data = olat_b;
            default:      rd_data = 8'h00;
        endcase
    end

    // Writable configuration and output latches
    always_ff @(posedge clk) begin
        if (rst) begin
            iodir_a   <= 8'hFF;
            iodir_b   <= 8'hFF;
            gpinten_a <= 8'h00;
            gpinten_b <= 8'h00;
            iocon     <= 8'h00;
            gppu_a    <= 8'h00;
            gppu_b    <= 8'h00;
            olat_a    <= 8'h00;
            olat_b    <= 8'h00;
        end else if (wr_en) begin
            case (ptr)
                8'h00:        iodir_a   <= rx_byte;
                8'h01:        iodir_b   <= rx_byte;
                8'h04:        gpinten_a <= rx_byte;
                8'h05:        gpinten_b <= rx_byte;
                8'h0A, 8'h0B: iocon     <= {rx_byte[7:1], 1'b0};
                8'h0C:        gppu_a    <= rx_byte;
                8'h0D:        gppu_b    <= rx_byte;
                8'h12, 8'h14: olat_a    <= rx_byte;
                8'h13, 8'h15: olat_b    <= rx_byte;
                default: ;
            endcase
        end else begin
            iodir_a <= iodir_a;
        end
    end

    assign chg_a = (gpa_s ^ gpa_prev) & gpinten_a & iodir_a;
    assign chg_b = (gpb_s ^ gpb_prev) & gpinten_b & iodir_b;
    assign clr_a = ld_en && ((ptr == 8'h10) || (ptr == 8'h12));
    assign clr_b = ld_en && ((ptr == 8'h11) || (ptr == 8'h13));
    assign act_a = |intf_a;
    assign act_b = |intf_b;
    assign pin_a = mirror ? (act_a | act_b) : act_a;
    assign pin_b = mirror ? (act_a | act_b) : act_b;

    // Interrupt capture (a new event beats a same-cycle clear) and pin drive
    always_ff @(posedge clk) begin
        if (rst) begin
            intf_a    <= 8'h00;
            intf_b    <= 8'h00;
            intcap_a  <= 8'h00;
            intcap_b  <= 8'h00;
            inta_r    <= 1'b1;
            intb_r    <= 1'b1;
            inta_oe_r <= 1'b1;
            intb_oe_r <= 1'b1;
        end else begin
            if ((chg_a != 8'h00) && ((intf_a == 8'h00) || clr_a)) begin
                intf_a   <= chg_a;
                intcap_a <= gpa_s;
            end else if (clr_a) begin
                intf_a <= 8'h00;
            end else begin
                intf_a <= intf_a;
            end
            if ((chg_b != 8'h00) && ((intf_b == 8'h00) || clr_b)) begin
                intf_b   <= chg_b;
                intcap_b <= gpb_s;
            end else if (clr_b) begin
                intf_b <= 8'h00;
            end else begin
                intf_b <= intf_b;
            end
            if (odr) begin
                inta_r    <= 1'b0;
                intb_r    <= 1'b0;
                inta_oe_r <= pin_a;
                intb_oe_r <= pin_b;
            end else begin
                inta_r    <= pin_a ^ ~intpol;
                intb_r    <= pin_b ^ ~intpol;
                inta_oe_r <= 1'b1;
                intb_oe_r <= 1'b1;
            end
        end
    end

    assign spi_miso    = tx_sh[7];
    assign spi_miso_oe = miso_oe_r;
    assign gpio_a_out  = olat_a;
    assign gpio_b_out  = olat_b;
    assign gpio_a_dir  = iodir_a;
    assign gpio_b_dir  = iodir_b;
    assign gpio_a_pu   = gppu_a;
    assign gpio_b_pu   = gppu_b;
    assign inta        = inta_r;
    assign intb        = intb_r;
    assign inta_oe     = inta_oe_r;
    assign intb_oe     = intb_oe_r;

endmodule

// File: tb/tb_mcp23s17_spi_responder.sv
// Scoreboard bench for mcp23s17_spi_responder: SPI master tasks push expected
// read bytes before each frame and pop them as MISO bytes arrive.
module tb_mcp23s17_spi_responder;

    localparam int SYNC = 2;
    localparam int H    = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_cs_n = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] gpio_a_in = 8'h00, gpio_b_in = 8'h5A;
    logic [7:0] gpio_a_out, gpio_b_out, gpio_a_dir, gpio_b_dir, gpio_a_pu, gpio_b_pu;
    logic       inta, intb, inta_oe, intb_oe;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    mcp23s17_spi_responder #(.HW_ADDR(3'b000), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .gpio_a_in(gpio_a_in), .gpio_b_in(gpio_b_in),
        .gpio_a_out(gpio_a_out), .gpio_b_out(gpio_b_out),
        .gpio_a_dir(gpio_a_dir), .gpio_b_dir(gpio_b_dir),
        .gpio_a_pu(gpio_a_pu), .gpio_b_pu(gpio_b_pu),
        .inta(inta), .intb(intb), .inta_oe(inta_oe), .intb_oe(intb_oe)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic oe);
        rx = 8'h00;
        oe = 1'b0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            tick(H);
            spi_sck = 1'b1;
            rx = {rx[6:0], spi_miso};
            oe = spi_miso_oe;
            tick(H);
            spi_sck = 1'b0;
        end
    endtask

    // Drives tx_q as one frame; data bytes of a read are matched against exp_q.
    task automatic run_frame(input string tag, input logic exp_oe, input int last_bits);
        logic [7:0] rx;
        logic       oe;
        int         n;
        int         left;
        n = tx_q.size();
        spi_cs_n = 1'b0;
        tick(H);
        for (int i = 0; i < n; i++) begin
            spi_byte(tx_q[i], (i == n - 1) ? last_bits : 8, rx, oe);
            if (i >= 2) begin
                check_val({tag, "_oe"}, {7'd0, oe}, {7'd0, exp_oe});
                if (exp_oe) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL %s: got byte %02h expected none (scoreboard empty)", tag, rx);
                    end else begin
                        check_val(tag, rx, exp_q.pop_front());
                    end
                end
            end
        end
        tick(H);
        spi_cs_n = 1'b1;
        tick(2 * H);
        left = exp_q.size();
        check_val({tag, "_left"}, 8'(left), 8'd0);
        exp_q.delete();
        tx_q.delete();
    endtask

    initial begin
        logic [7:0] rx;
        logic       oe;
        logic       hit;

        tick(6);
        rst = 1'b0;
        tick(2);
        check_val("rst_miso", {7'd0, spi_miso}, 8'd0);
        check_val("rst_oe", {7'd0, spi_miso_oe}, 8'd0);
        check_val("rst_inta", {7'd0, inta}, 8'd1);
        check_val("rst_intb", {7'd0, intb}, 8'd1);
        check_val("rst_inta_oe", {7'd0, inta_oe}, 8'd1);
        check_val("rst_intb_oe", {7'd0, intb_oe}, 8'd1);
        check_val("rst_dir_a", gpio_a_dir, 8'hFF);
        check_val("rst_dir_b", gpio_b_dir, 8'hFF);
        check_val("rst_out_a", gpio_a_out, 8'h00);
        check_val("rst_pu_b", gpio_b_pu, 8'h00);

        // IOCON write/readback; INTPOL=1 drives idle level low
        tx_q = '{8'h40, 8'h0A, 8'h52};
        run_frame("iocon_wr", 1'b0, 8);
        tx_q = '{8'h41, 8'h0A, 8'h00};
        exp_q.push_back(8'h52);
        run_frame("iocon_rd", 1'b1, 8);
        check_val("inta_idle", {7'd0, inta}, 8'd0);
        check_val("intb_idle", {7'd0, intb}, 8'd0);
        check_val("out_a_keep", gpio_a_out, 8'h00);
        check_val("dir_a_keep", gpio_a_dir, 8'hFF);

        // OLAT write, GPIO read as output then as input
        tx_q = '{8'h40, 8'h00, 8'h00};
        run_frame("iodir_wr", 1'b0, 8);
        tx_q = '{8'h40, 8'h14, 8'hA5};
        run_frame("olat_wr", 1'b0, 8);
        check_val("out_a", gpio_a_out, 8'hA5);
        check_val("dir_a", gpio_a_dir, 8'h00);
        tx_q = '{8'h41, 8'h12, 8'h00};
        exp_q.push_back(8'hA5);
        run_frame("gpio_rd_out", 1'b1, 8);
        tx_q = '{8'h40, 8'h00, 8'hFF};
        run_frame("iodir_wr2", 1'b0, 8);
        gpio_a_in = 8'h3C;
        tick(8);
        tx_q = '{8'h41, 8'h12, 8'h00};
        exp_q.push_back(8'h3C);
        run_frame("gpio_rd_in", 1'b1, 8);
        tx_q = '{8'h40, 8'h0C, 8'h81, 8'h7E};
        run_frame("gppu_burst", 1'b0, 8);
        check_val("pu_a", gpio_a_pu, 8'h81);
        check_val("pu_b", gpio_b_pu, 8'h7E);

        // Interrupt on change, capture, clear on GPIO read
        gpio_a_in = 8'hFF;
        tick(8);
        tx_q = '{8'h40, 8'h04, 8'hFF};
        run_frame("gpinten_wr", 1'b0, 8);
        check_val("inta_pre", {7'd0, inta}, 8'd0);
        gpio_a_in = 8'hFB;
        hit = 1'b0;
        for (int k = 0; k < SYNC + 2; k++) begin
            tick(1);
            if (inta) begin
                hit = 1'b1;
                break;
            end
        end
        check_val("inta_set", {7'd0, hit}, 8'd1);
        check_val("intb_mirror", {7'd0, intb}, 8'd1);
        tx_q = '{8'h41, 8'h0E, 8'h00};
        exp_q.push_back(8'h04);
        run_frame("intf_rd", 1'b1, 8);
        check_val("inta_hold", {7'd0, inta}, 8'd1);
        tx_q = '{8'h41, 8'h12, 8'h00};
        exp_q.push_back(8'hFB);
        run_frame("gpio_rd_int", 1'b1, 8);
        check_val("inta_clr", {7'd0, inta}, 8'd0);
        tx_q = '{8'h41, 8'h10, 8'h00};
        exp_q.push_back(8'hFB);
        run_frame("intcap_rd", 1'b1, 8);

        // Open-drain interrupt mode
        tx_q = '{8'h40, 8'h0A, 8'h44};
        run_frame("iocon_odr", 1'b0, 8);
        check_val("odr_oe_idle", {7'd0, inta_oe}, 8'd0);
        gpio_a_in = 8'hFA;
        tick(SYNC + 4);
        check_val("odr_oe_act", {7'd0, inta_oe}, 8'd1);
        check_val("odr_lvl", {7'd0, inta}, 8'd0);
        check_val("odr_intb_oe", {7'd0, intb_oe}, 8'd1);
        tx_q = '{8'h41, 8'h12, 8'h00};
        exp_q.push_back(8'hFA);
        run_frame("odr_gpio_rd", 1'b1, 8);
        check_val("odr_oe_clr", {7'd0, inta_oe}, 8'd0);
        tx_q = '{8'h40, 8'h0A, 8'h02};
        run_frame("iocon_rest", 1'b0, 8);

        // Sequential write wrapping 0x15 -> 0x00, then burst read
        tx_q = '{8'h40, 8'h15, 8'hC3, 8'h0F};
        run_frame("wrap_wr", 1'b0, 8);
        check_val("wrap_olatb", gpio_b_out, 8'hC3);
        check_val("wrap_iodira", gpio_a_dir, 8'h0F);
        tx_q = '{8'h41, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hC3);
        run_frame("burst_rd", 1'b1, 8);

        // Hardware addressing: mismatched opcodes are ignored
        tx_q = '{8'h40, 8'h0A, 8'h0A};
        run_frame("haen_on", 1'b0, 8);
        tx_q = '{8'h42, 8'h14, 8'hFF};
        run_frame("haen_wr_ign", 1'b0, 8);
        check_val("haen_out_a", gpio_a_out, 8'hA5);
        tx_q = '{8'h43, 8'h14, 8'h00};
        run_frame("haen_rd_ign", 1'b0, 8);
        tx_q = '{8'h41, 8'h0A, 8'h00};
        exp_q.push_back(8'h0A);
        run_frame("haen_match", 1'b1, 8);
        tx_q = '{8'h40, 8'h0A, 8'h02};
        run_frame("haen_off", 1'b0, 8);

        // Unmapped read, RO write ignored
        tx_q = '{8'h41, 8'h20, 8'h00};
        exp_q.push_back(8'h00);
        run_frame("unmapped_rd", 1'b1, 8);
        tx_q = '{8'h40, 8'h10, 8'h55};
        run_frame("ro_wr", 1'b0, 8);
        tx_q = '{8'h41, 8'h10, 8'h00};
        exp_q.push_back(8'hFA);
        run_frame("ro_rd", 1'b1, 8);

        // Partial data byte discarded
        tx_q = '{8'h40, 8'h00, 8'h00};
        run_frame("partial", 1'b0, 5);
        check_val("partial_dir", gpio_a_dir, 8'h0F);

        // Reset mid-frame: registers revert, rest of frame ignored
        spi_cs_n = 1'b0;
        tick(H);
        spi_byte(8'h40, 8, rx, oe);
        spi_byte(8'h14, 8, rx, oe);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        spi_byte(8'hFF, 8, rx, oe);
        tick(H);
        spi_cs_n = 1'b1;
        tick(2 * H);
        check_val("mid_out_a", gpio_a_out, 8'h00);
        check_val("mid_dir_a", gpio_a_dir, 8'hFF);
        check_val("mid_out_b", gpio_b_out, 8'h00);
        check_val("mid_pu_a", gpio_a_pu, 8'h00);
        check_val("mid_inta", {7'd0, inta}, 8'd1);
        tx_q = '{8'h41, 8'h14, 8'h00};
        exp_q.push_back(8'h00);
        run_frame("post_rst_rd", 1'b1, 8);
        tx_q = '{8'h41, 8'h0A, 8'h00};
        exp_q.push_back(8'h00);
        run_frame("post_rst_iocon", 1'b1, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mcp23s17_spi_responder.md
Name: mcp23s17_spi_responder

Overview:
- SPI-mode-0 responder that emulates the MCP23S17 register subset used by our expander drivers.
- Serves as the far-end model in benches for the joystick/GPIO SPI initiator.
- Also acts as an FPGA-side expander in bridge builds, driving port pins and the interrupt line back to an external master.
- Runs in the system clock domain; the SPI signals are oversampled.

Parameters:
- HW_ADDR, 3'b000, hardware address A2..A0, compared only when IOCON.HAEN=1.
- SYNC_STAGES, 2, synchroniser depth on cs_n/sck/mosi/gpio inputs (2..3).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- spi_cs_n  in  1  chip select, active low
- spi_sck  in  1  SPI clock, mode 0
- spi_mosi  in  1  serial data in
- spi_miso  out  1  serial data out
- spi_miso_oe  out  1  MISO tri-state enable
- gpio_a_in, gpio_b_in  in  8 each  pin levels
- gpio_a_out, gpio_b_out  out  8 each  OLATA/OLATB
- gpio_a_dir, gpio_b_dir  out  8 each  IODIRA/IODIRB (1 = input)
- gpio_a_pu, gpio_b_pu  out  8 each  GPPUA/GPPUB
- inta, intb  out  1 each  interrupt level
- inta_oe, intb_oe  out  1 each  interrupt pad drive enable

Behaviour:
- Reset is rst, synchronous, active-high; the clock is clk.
- Inputs pass through SYNC_STAGES flops; SCK edges are detected on the synchronised signal.
- Host SCK half-period must be ≥ SYNC_STAGES+2 clk.
- Registers (BANK=0 map only). Reset values: IODIRA/B=FF; all others 00.
  - 00/01 IODIR
  - 04/05 GPINTEN
  - 0A/0B IOCON (shared; {BANK ignored, MIRROR, SEQOP, DISSLW ignored, HAEN, ODR, INTPOL, 0})
  - 0C/0D GPPU
  - 0E/0F INTF (RO)
  - 10/11 INTCAP (RO)
  - 12/13 GPIO
  - 14/15 OLAT
  - Any other address reads 00; writes to it are ignored. Writes to RO registers are ignored.
- GPIO read value per bit = IODIR ? synced pin : OLAT. A GPIO write updates OLAT.
- Frame FSM states: IDLE, OPCODE, ADDR, DATA, IGNORE.
  - cs_n falling -> OPCODE, bit counter cleared.
  - Bits are sampled on SCK rising, MSB first.
  - After 8 bits of OPCODE: if bits[7:4]≠0100, or (HAEN=1 and bits[3:1]≠HW_ADDR) -> IGNORE. Otherwise latch R/W=bit0 -> ADDR.
  - After 8 address bits -> DATA, pointer = address byte.
  - DATA, write: on the 8th bit, commit the byte to the pointer; pointer advances.
  - DATA, read: register[pointer] is loaded into the TX shift register on the SCK falling edge following the 8th bit of the previous byte; pointer advances at that load.
  - MISO shifts on SCK falling edges. spi_miso_oe=1 only in DATA with R/W=1 and cs_n low.
  - Pointer advance: SEQOP=0 -> +1, wrapping 0x15->0x00. SEQOP=1 -> unchanged.
- cs_n high at any time -> IDLE, miso_oe=0, any partial byte discarded. Already-committed bytes stand.
- Interrupt, compare-to-previous mode only, per port:
  - Change = synced pin XOR previous synced sample, masked by GPINTEN & IODIR.
  - If INTF==0 and change≠0: INTF<=change, INTCAP<=synced pins.
  - While INTF≠0, further changes are ignored.
  - Clear INTF when a GPIO or INTCAP byte of that port is loaded into the TX shift register.
  - A set event in the same cycle as a clear wins: new INTF and INTCAP are taken.
- Interrupt outputs:
  - Per-port active = |INTF. MIRROR=1 -> both pins show active_a|active_b.
  - ODR=0: pin level = active ^ ~INTPOL; int_oe=1.
  - ODR=1: pin level=0; int_oe=active. INTPOL is ignored.
- Reset values: spi_miso=0, spi_miso_oe=0, inta=intb=1, inta_oe=intb_oe=1, gpio_*_dir=FF, gpio_*_out=00, gpio_*_pu=00.
- Reset asserted mid-frame: all registers return to reset values. The FSM is held in IDLE until the next cs_n falling edge; the remainder of the current frame is ignored.

Test Plan:
- Write 40 0A 52 then read 41 0A xx -> MISO returns 52; inta idles 0 (INTPOL=1); outputs unchanged.
- Write 40 14 A5 with IODIRA=00 -> gpio_a_out=A5. Read 41 12 -> A5. Set IODIRA=FF, gpio_a_in=3C -> read 41 12 returns 3C.
- GPINTENA=FF, IOCON=52, flip gpio_a_in bit 2 (FF->FB) -> inta=1 within SYNC_STAGES+2 clk, INTFA=04, INTCAPA=FB. Read 41 12 -> inta=0.
- SEQOP=0, burst read 41 12 xx xx xx xx -> bytes GPIOA, GPIOB, OLATA, OLATB. Write burst starting at 15 -> wraps to IODIRA.
- HAEN=1, opcode 42 (address 001) with HW_ADDR=000 -> frame ignored, miso_oe stays 0, no register changes.
- cs_n raised after 5 bits of the data byte in 40 00 xx -> IODIRA unchanged (FF). rst pulsed mid-frame -> all registers back to reset values; bytes after reset are ignored until cs_n toggles.
